// File: rtl/instruction_fetcher.sv
// Single-outstanding instruction fetcher. It predicts branches through an
// external predictor and fills an in-order instruction queue for the decoder.
module instruction_fetcher #(
  parameter int IQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_pc,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic        pred_query,
  output logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_inst,
  output logic [31:0] dq_pc,
  output logic        dq_pred_taken
);
  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IDLE, WAIT_MEM, PRED_ISSUE, PRED_READ, DROP} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  state_t        state;
  logic [31:0]   pc, inst_q;
  iq_entry_t     iq [IQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic          enq, deq;
  iq_entry_t     enq_entry;
  logic [31:0]   next_pc, imm_b, imm_j;
  logic [6:0]    opcode;

  assign opcode = icache_resp_inst[6:0];
  // Branch offset comes from the latched instruction, JAL offset from the live response.
  assign imm_b = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_j = {{12{icache_resp_inst[31]}}, icache_resp_inst[19:12],
                  icache_resp_inst[20], icache_resp_inst[30:21], 1'b0};

  always_comb begin
    enq       = 1'b0;
    enq_entry = '0;
    next_pc   = pc + 32'd4;
    case (state)
      WAIT_MEM: if (icache_resp_valid && opcode != OP_BRANCH) begin
        enq = 1'b1;
        if (opcode == OP_JAL) begin
          enq_entry = '{inst: icache_resp_inst, pc: pc, pred: 1'b1};
          next_pc   = pc + imm_j;
        end else begin
          enq_entry = '{inst: icache_resp_inst, pc: pc, pred: 1'b0};
        end
      end
      PRED_READ: begin
        enq       = 1'b1;
        enq_entry = '{inst: inst_q, pc: pc, pred: pred_taken};
        if (pred_taken) next_pc = pc + imm_b;
      end
      default: ;
    endcase
    enq = enq && rdy_in && !flush_in;
  end

  assign dq_valid = (count != '0);
  assign deq      = dq_valid && dq_ready && rdy_in && !flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      pc               <= '0;
      inst_q           <= '0;
      icache_req_valid <= 1'b0;
      icache_req_pc    <= '0;
      pred_query       <= 1'b0;
      pred_pc          <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc         <= flush_pc_in;
        pred_query <= 1'b0;
        // An unanswered request must still be retired, so its response is swallowed in DROP.
        if (state == WAIT_MEM && !icache_resp_valid) begin
          state <= DROP;
        end else begin
          state            <= IDLE;
          icache_req_valid <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (int'(count) < IQ_DEPTH) begin
            icache_req_valid <= 1'b1;
            icache_req_pc    <= pc;
            state            <= WAIT_MEM;
          end
          WAIT_MEM: if (icache_resp_valid) begin
            icache_req_valid <= 1'b0;
            inst_q           <= icache_resp_inst;
            if (opcode == OP_BRANCH) begin
              pred_query <= 1'b1;
              pred_pc    <= pc;
              state      <= PRED_ISSUE;
            end else begin
              pc    <= next_pc;
              state <= IDLE;
            end
          end
          PRED_ISSUE: begin
            pred_query <= 1'b0;
            state      <= PRED_READ;
          end
          PRED_READ: begin
            pc    <= next_pc;
            state <= IDLE;
          end
          DROP: if (icache_resp_valid) begin
            icache_req_valid <= 1'b0;
            state            <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) iq[wr_ptr] <= enq_entry;
  end

  assign dq_inst       = iq[rd_ptr].inst;
  assign dq_pc         = iq[rd_ptr].pc;
  assign dq_pred_taken = iq[rd_ptr].pred;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: stimulus pushes expected queue
// entries, an independent monitor pops them on every decoder handshake.
module tb_instruction_fetcher;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        icache_req_valid;
  logic [31:0] icache_req_pc;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic        pred_query;
  logic [31:0] pred_pc;
  logic        pred_taken, flush_in;
  logic [31:0] flush_pc_in;
  logic        dq_valid, dq_ready, dq_pred_taken;
  logic [31:0] dq_inst, dq_pc;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] BEQ16  = 32'h00000863;
  localparam logic [31:0] JALM8  = 32'hFF9FF06F;
  localparam logic [31:0] JALM16 = 32'hFF1FF06F;
  localparam logic [31:0] JALP8  = 32'h0080006F;

  instruction_fetcher #(.IQ_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_valid(icache_req_valid), .icache_req_pc(icache_req_pc),
    .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
    .pred_query(pred_query), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .flush_in(flush_in), .flush_pc_in(flush_pc_in),
    .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_inst(dq_inst),
    .dq_pc(dq_pc), .dq_pred_taken(dq_pred_taken)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs settle at the falling edge, so one step later they reflect what the next rising edge sees.
  always @(negedge clk_in) begin
    #1;
    if (!rst_in && rdy_in && !flush_in && dq_valid && dq_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_entry_pc", dq_pc, 32'hDEADBEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dq_inst", dq_inst, e.inst);
        chk("dq_pc", dq_pc, e.pc);
        chk("dq_pred", 32'(dq_pred_taken), 32'(e.pred));
      end
    end
  end

  task automatic wait_req(input logic [31:0] exp_pc);
    int n = 0;
    @(negedge clk_in);
    while (!icache_req_valid && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("req_valid_seen", 32'(icache_req_valid), 32'd1);
    if (icache_req_valid) chk("req_pc", icache_req_pc, exp_pc);
  endtask

  task automatic respond(input logic [31:0] inst);
    icache_resp_valid = 1'b1;
    icache_resp_inst  = inst;
    @(negedge clk_in);
    icache_resp_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
    wait_req(pc);
    exp_q.push_back('{inst: inst, pc: pc, pred: pred});
    respond(inst);
  endtask

  task automatic fetch_br(input logic [31:0] pc, input logic taken);
    wait_req(pc);
    respond(BEQ16);
    chk("pred_query_pulse", 32'(pred_query), 32'd1);
    chk("pred_pc", pred_pc, pc);
    pred_taken = taken;
    exp_q.push_back('{inst: BEQ16, pc: pc, pred: taken});
    @(negedge clk_in);
    chk("pred_query_drop", 32'(pred_query), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; icache_resp_valid = 1'b0; icache_resp_inst = '0;
    pred_taken = 1'b0; flush_in = 1'b0; flush_pc_in = '0; dq_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
    chk("rst_req_pc", icache_req_pc, 32'd0);
    chk("rst_pred_query", 32'(pred_query), 32'd0);
    chk("rst_pred_pc", pred_pc, 32'd0);
    chk("rst_dq_valid", 32'(dq_valid), 32'd0);
    rst_in = 1'b0;

    // Straight-line, branch, JAL and wrap-around PC sequencing
    fetch(32'h0, ADDI, 1'b0);
    fetch(32'h4, NOP, 1'b0);
    fetch_br(32'h8, 1'b1);
    fetch(32'h18, JALM8, 1'b1);
    fetch(32'h10, JALM8, 1'b1);
    fetch_br(32'h8, 1'b0);
    fetch(32'hC, JALM16, 1'b1);
    fetch(32'hFFFFFFFC, JALP8, 1'b1);

    // Fill the queue with the decoder stalled
    wait_req(32'h4);
    dq_ready = 1'b0;
    exp_q.push_back('{inst: NOP, pc: 32'h4, pred: 1'b0});
    respond(NOP);
    for (int k = 1; k < 8; k++) fetch(32'h4 + 32'(4 * k), NOP, 1'b0);
    repeat (6) begin
      @(negedge clk_in);
      chk("full_no_req", 32'(icache_req_valid), 32'd0);
    end
    chk("full_dq_valid", 32'(dq_valid), 32'd1);
    dq_ready = 1'b1;
    @(negedge clk_in);
    dq_ready = 1'b0;
    fetch(32'h24, NOP, 1'b0);
    dq_ready = 1'b1;

    // Flush while waiting on memory; late response must be discarded
    wait_req(32'h28);
    dq_ready = 1'b0; flush_in = 1'b1; flush_pc_in = 32'h100;
    exp_q.delete();
    @(negedge clk_in);
    flush_in = 1'b0;
    chk("flush_dq_empty", 32'(dq_valid), 32'd0);
    chk("drop_req_held", 32'(icache_req_valid), 32'd1);
    @(negedge clk_in);
    chk("drop_req_held2", 32'(icache_req_valid), 32'd1);
    respond(JALP8);
    dq_ready = 1'b1;
    wait_req(32'h100);
    chk("drop_no_entry", 32'(dq_valid), 32'd0);
    exp_q.push_back('{inst: NOP, pc: 32'h100, pred: 1'b0});
    respond(NOP);

    // Stall in PRED_READ; a flush during the stall must be ignored
    fetch_br(32'h104, 1'b1);
    rdy_in = 1'b0; flush_in = 1'b1; flush_pc_in = 32'h200;
    repeat (3) begin
      @(negedge clk_in);
      flush_in = 1'b0;
      chk("stall_no_enq", 32'(dq_valid), 32'd0);
      chk("stall_no_req", 32'(icache_req_valid), 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("stall_release_enq", 32'(dq_valid), 32'd1);
    wait_req(32'h114);

    // Reset in the middle of a fetch restarts from PC 0 with nothing queued
    rst_in = 1'b1;
    exp_q.delete();
    @(negedge clk_in);
    chk("midrst_req_valid", 32'(icache_req_valid), 32'd0);
    chk("midrst_dq_valid", 32'(dq_valid), 32'd0);
    rst_in = 1'b0;
    fetch(32'h0, NOP, 1'b0);
    repeat (4) @(negedge clk_in);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8, meaning instruction-queue entries (power of two).
REQ-002 SHALL have port clk_in input 1: system clock; the block uses only this clock.
REQ-003 SHALL have port rst_in input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port rdy_in input 1: when low, all state holds.
REQ-005 SHALL have port icache_req_valid output 1: fetch request, held until response.
REQ-006 SHALL have port icache_req_pc output 32: fetch address.
REQ-007 SHALL have port icache_resp_valid input 1: instruction valid, one-cycle pulse.
REQ-008 SHALL have port icache_resp_inst input 32: fetched instruction.
REQ-009 SHALL have port pred_query output 1: prediction request to branch predictor, one-cycle pulse.
REQ-010 SHALL have port pred_pc output 32: branch PC for prediction.
REQ-011 SHALL have port pred_taken input 1: predictor answer, valid the cycle after the predictor samples pred_query.
REQ-012 SHALL have port flush_in input 1: misprediction redirect.
REQ-013 SHALL have port flush_pc_in input 32: redirect target.
REQ-014 SHALL have port dq_valid output 1: queue non-empty.
REQ-015 SHALL have port dq_ready input 1: decoder accepts head entry.
REQ-016 SHALL have ports dq_inst output 32, dq_pc output 32 and dq_pred_taken output 1: head-entry instruction, PC and prediction.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_MEM, PRED_ISSUE, PRED_READ, DROP, with all outputs registered except dq_*.
REQ-018 SHALL, in IDLE when count<IQ_DEPTH, set icache_req_valid=1 and icache_req_pc=pc, then go to WAIT_MEM; otherwise it SHALL stay in IDLE.
REQ-019 SHALL, in WAIT_MEM on icache_resp_valid, drop icache_req_valid and latch the instruction.
REQ-020 SHALL, in WAIT_MEM on response with opcode 1100011 (branch), pulse pred_query=1 with pred_pc=pc and go to PRED_ISSUE.
REQ-021 SHALL, in WAIT_MEM on response with opcode 1101111 (JAL), enqueue {inst,pc,1}, set pc=pc+immJ and go to IDLE.
REQ-022 SHALL, in WAIT_MEM on response with any other opcode (including JALR), enqueue {inst,pc,0}, set pc=pc+4 and go to IDLE.
REQ-023 SHALL, in PRED_ISSUE, deassert pred_query and go to PRED_READ without any other action.
REQ-024 SHALL, in PRED_READ, sample pred_taken, enqueue {inst,pc,pred_taken}, set pc=pred_taken?pc+immB:pc+4 and go to IDLE.
REQ-025 SHALL use immB={{20{i[31]}},i[7],i[30:25],i[11:8],0} and immJ={{12{i[31]}},i[19:12],i[20],i[30:21],0}, with all PC sums wrapping modulo 2^32.
REQ-026 SHALL keep at most one fetch outstanding, so the issue-time check count<IQ_DEPTH guarantees that no enqueue occurs while the queue is full.
REQ-027 SHALL drive dq_valid=(count!=0) and dq_* from the head entry combinationally.
REQ-028 SHALL dequeue when dq_valid && dq_ready && rdy_in.
REQ-029 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers, which wrap at IQ_DEPTH.
REQ-030 SHALL give flush_in the highest priority: queue emptied (count=0, pointers 0), pc=flush_pc_in, pred_query=0.
REQ-031 SHALL, on flush_in, go to DROP if state was WAIT_MEM and icache_resp_valid is low that cycle; otherwise it SHALL go to IDLE.
REQ-032 SHALL, in DROP, keep icache_req_valid=1 until icache_resp_valid, discard that response and go to IDLE.
REQ-033 SHALL ignore a dequeue that coincides with flush_in.
REQ-034 SHALL, when rdy_in=0, hold all registers, with flush_in, icache_resp_valid and dq_ready ignored.

Reset
REQ-035 SHALL, on rst_in=1 and regardless of clock, set state=IDLE, pc=0, count=0, pointers=0, icache_req_valid=0, icache_req_pc=0, pred_query=0 and pred_pc=0; dq_valid is then 0.
REQ-036 SHALL, on reset mid-operation, abandon any in-flight fetch or prediction with no queue entry produced.

Verification
REQ-037 SHALL cover reset, then addi (0x00100093) at pc 0 -> queue entry {0x00100093,0x0,0}, next request pc 0x4.
REQ-038 SHALL cover branch beq x0,x0,+16 (0x00000863) at 0x8 with pred_taken=1 -> pred_query pulse with pred_pc=0x8, entry pred=1, next pc 0x18; with pred_taken=0 -> next pc 0xC.
REQ-039 SHALL cover JAL -8 (0xFF9FF06F) at 0x10 -> entry pred=1, next pc 0x8; and JAL at 0xFFFFFFFC with +8 -> next pc 0x4 (wrap).
REQ-040 SHALL cover dq_ready=0 for 8 non-branch fetches -> count=8, icache_req_valid stays 0; one dequeue -> a fetch is issued.
REQ-041 SHALL cover flush_in with flush_pc_in=0x100 in WAIT_MEM, response arriving 2 cycles later -> response discarded, queue empty, next request pc 0x100.
REQ-042 SHALL cover rdy_in=0 for 3 cycles in PRED_READ -> no state change; on rdy_in=1 -> one enqueue.
